// File: rtl/spi_cfg_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_cfg_arbiter_if
//   Bundles the requester-side and serializer-side signals of the SPI config
//   arbiter.
//   master modport : the arbiter (drives acks/pulses and the serializer frame)
//   slave modport  : the environment (requesters and the P2S serializer)
//   Requester i occupies req_data[i*DATA_W +: DATA_W] and
//   req_width[i*WID_W +: WID_W]. Parameters must match the arbiter's.
// ---------------------------------------------------------------------------
interface spi_cfg_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int WID_W   = 8
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*WID_W-1:0]  req_width;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  // serializer side
  logic                      p2s_start;
  logic [DATA_W-1:0]         p2s_data;
  logic [31:0]               p2s_width;
  logic                      p2s_busy;
  logic                      p2s_completed;
  // status
  logic                      arb_busy;
  logic [OWN_W-1:0]          arb_owner;

  modport master (
    input  req_valid, req_data, req_width, p2s_busy, p2s_completed,
    output req_ack, req_done, req_err, p2s_start, p2s_data, p2s_width,
           arb_busy, arb_owner
  );

  modport slave (
    output req_valid, req_data, req_width, p2s_busy, p2s_completed,
    input  req_ack, req_done, req_err, p2s_start, p2s_data, p2s_width,
           arb_busy, arb_owner
  );
endinterface

// File: rtl/spi_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// spi_cfg_arbiter
//   Round-robin arbiter sharing one parallel-to-serial SPI serializer among
//   NUM_REQ register-configuration requesters. One frame in flight at a time;
//   each finished frame is followed by a GAP_CYCLES chip-select-high gap.
//
// Ports
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : spi_cfg_arbiter_if.master
//          req_valid/req_data/req_width in, req_ack/req_done/req_err pulses out,
//          p2s_start/p2s_data/p2s_width out, p2s_busy/p2s_completed in,
//          arb_busy/arb_owner status out
//
// Optional feature
//   SPI_ARB_TIMEOUT_EN : when defined, WAIT_DONE gives up after TIMEOUT_CYCLES
//                        clocks without p2s_completed, pulses req_err[owner]
//                        and proceeds to GAP. When undefined req_err is 0.
// ---------------------------------------------------------------------------
module spi_cfg_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_W         = 16,
  parameter int WID_W          = 8,
  parameter int GAP_CYCLES     = 120,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input logic                clk,
  input logic                rst,
  spi_cfg_arbiter_if.master  bus
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // GAP and WAIT_DONE never overlap, so one counter serves both. Without the
  // timeout feature it is sized for the gap alone.
  localparam int CNT_MAX = (TO_EN && (TIMEOUT_CYCLES > GAP_CYCLES)) ?
                           TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_e;

  state_e             state;
  logic [OWN_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               sel_found;
  logic [OWN_W-1:0]   sel;
  logic [DATA_W-1:0]  sel_data;
  logic [WID_W-1:0]   sel_width;
  logic [31:0]        clamp_width;
  logic [OWN_W:0]     scan_idx;

  // Round-robin pick: first asserted request scanning upward from rr_ptr.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    sel_data  = '0;
    sel_width = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (OWN_W+1)'(k);
      if (scan_idx >= (OWN_W+1)'(NUM_REQ)) scan_idx = scan_idx - (OWN_W+1)'(NUM_REQ);
      if (!sel_found && bus.req_valid[scan_idx[OWN_W-1:0]]) begin
        sel_found = 1'b1;
        sel       = scan_idx[OWN_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == OWN_W'(i)) begin
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
        sel_width = bus.req_width[i*WID_W +: WID_W];
      end
    end
  end

  // Widths beyond the shift register are clamped rather than rejected.
  assign clamp_width = (32'(sel_width) > 32'(DATA_W)) ? 32'(DATA_W) : 32'(sel_width);

  assign bus.arb_busy = (state != IDLE);

`ifndef SPI_ARB_TIMEOUT_EN
  assign bus.req_err = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      bus.req_ack   <= '0;
      bus.req_done  <= '0;
      bus.p2s_start <= 1'b0;
      bus.p2s_data  <= '0;
      bus.p2s_width <= '0;
      bus.arb_owner <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      bus.req_err   <= '0;
`endif
    end else begin
      // pulse outputs default low each cycle
      bus.req_ack   <= '0;
      bus.req_done  <= '0;
      bus.p2s_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      bus.req_err   <= '0;
`endif
      case (state)
        IDLE: begin
          if (sel_found && !bus.p2s_busy) begin
            state         <= ISSUE;
            bus.arb_owner <= sel;
            bus.p2s_data  <= sel_data;
            bus.p2s_width <= clamp_width;
            bus.req_ack   <= NUM_REQ'(1) << sel;
            bus.p2s_start <= (sel_width != '0);
            rr_ptr        <= (sel == OWN_W'(NUM_REQ-1)) ? '0 : sel + OWN_W'(1);
          end
        end
        ISSUE: begin
          // a zero-width frame completes immediately and skips the gap
          if (bus.p2s_width == '0) begin
            bus.req_done <= NUM_REQ'(1) << bus.arb_owner;
            state        <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // completion takes priority over a same-cycle timeout
          if (bus.p2s_completed) begin
            bus.req_done <= NUM_REQ'(1) << bus.arb_owner;
            cnt          <= '0;
            state        <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            bus.req_err <= NUM_REQ'(1) << bus.arb_owner;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES-1)) state <= IDLE;
          else                             cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

Round-robin arbiter that shares the single parallel-to-serial SPI serializer between several register-configuration requesters (DAC, clock chip, ADC config engines). Each requester presents a frame word and bit width. The arbiter grants one at a time, issues the serializer start pulse, waits for frame completion, and enforces a CS-high guard gap between frames. It sits between the per-device register sequencers and the serializer inside the board-level config module.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 16, frame data width; matches serializer shift-register width
- WID_W, 8, per-requester width field; zero-extended to 32 on p2s_width
- GAP_CYCLES, 120, idle clocks between frames (1 us at 120 MHz), >=1
- TIMEOUT_CYCLES, 4000, WAIT_DONE watchdog limit (only with macro)

Ports:
- clk  in  1  system clock (120 MHz)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  level request; held until req_ack
- req_data  in  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
- req_width  in  NUM_REQ*WID_W  requester i at [i*WID_W +: WID_W]
- req_ack  out  NUM_REQ  1-cycle pulse: request captured
- req_done  out  NUM_REQ  1-cycle pulse: frame finished
- req_err  out  NUM_REQ  1-cycle pulse: frame timed out
- p2s_start  out  1  1-cycle start pulse to serializer
- p2s_data  out  DATA_W  frame data, held stable from start until next grant
- p2s_width  out  32  frame bit count, held like p2s_data
- p2s_busy  in  1  serializer busy
- p2s_completed  in  1  serializer frame-complete pulse
- arb_busy  out  1  high in any state except IDLE
- arb_owner  out  max(1,$clog2(NUM_REQ))  index of current/last grant

## Operation
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: if any req_valid and p2s_busy==0, select the first asserted index scanning from rr_ptr upward with wrap. Latch data, width, and owner. Go to ISSUE. If p2s_busy==1, no grant.
- ISSUE (1 cycle): req_ack[owner]=1.
  - Width in 1..DATA_W: p2s_start=1, go to WAIT_DONE.
  - Width > DATA_W: clamp to DATA_W, then as above.
  - Width == 0: no p2s_start; req_done[owner] pulses the next cycle; go to IDLE with no gap.
- rr_ptr <= owner+1 (wrapping at NUM_REQ) on every grant.
- WAIT_DONE: on p2s_completed, pulse req_done[owner] next cycle and go to GAP.
- p2s_completed outside WAIT_DONE is ignored.
- GAP: count GAP_CYCLES clocks, then go to IDLE.
- Reset values: all outputs 0; state IDLE; rr_ptr 0; gap and timeout counters 0.
- Reset mid-frame: arbiter returns to IDLE immediately with no done/err pulses. The serializer is not aborted by this block. Requesters must re-request.
- A requester dropping req_valid after ack has no effect on the frame in flight.

## Timing
- req_valid sampled high in IDLE at cycle T → ISSUE at T+1: p2s_start, req_ack, and stable p2s_data/p2s_width all valid at T+1.
- p2s_completed at cycle C → req_done at C+1. GAP occupies C+1..C+GAP_CYCLES. Earliest next p2s_start is C+GAP_CYCLES+2.
- Width 0: ack at T+1, done at T+2, IDLE at T+2.
- Max one frame in flight. Worst-case wait for requester i is (NUM_REQ-1) full frames plus gaps.

## Configuration
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_DONE counts clocks.
  - If TIMEOUT_CYCLES elapse without p2s_completed, pulse req_err[owner] (no req_done) and enter GAP.
  - A p2s_completed arriving on the timeout cycle wins: done, not err.
- Undefined: WAIT_DONE waits indefinitely; req_err tied to 0; the counter is not synthesized.

## Test plan
- Single request, requester 1, data 16'hA5C3, width 16, serializer model completes 200 cycles after start → ack/start at T+1, p2s_data 16'hA5C3, done 1 cycle after completed, next grant no earlier than GAP_CYCLES later.
- All three requesting continuously from reset → grant order 0,1,2,0,1,2; exactly one ack per frame.
- Width 0 on requester 2 → ack then done the next cycle, no p2s_start, arb_busy low at T+2. Width 40 → p2s_width 16.
- p2s_busy held high, req_valid[0]=1 → no grant until busy falls; grant on the cycle after busy samples 0. A stray p2s_completed in IDLE produces no pulse.
- rst asserted 5 cycles after p2s_start → all outputs 0 asynchronously. After release, a pending req_valid[1] is granted with rr_ptr=0 scanning.
- SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, completed never arrives → req_err[owner] pulse 50 cycles into WAIT_DONE, no req_done, GAP then IDLE.
